usb_tx_packet_shifter: RTL and testbench

- Serialises one outgoing USB packet (SYNC, PID, optional DATA bytes, CRC16, EOP) into a bit stream for the downstream NRZI encoder.
- Drives `d_orig`, `idle`, `eop` and the per-field shift enables that the encoder consumes.
- Performs bit stuffing and CRC16 generation.
- Sits between the TX protocol controller/FIFO (byte handshake) and the NRZI encoder.

---
 rtl/usb_tx_packet_shifter_pkg.sv | 22 ++
 rtl/usb_tx_packet_shifter_if.sv | 23 ++
 rtl/usb_tx_packet_shifter_crc16.sv | 28 ++
 rtl/usb_tx_packet_shifter.sv | 217 +++++++++++++++++++++
 tb/tb_usb_tx_packet_shifter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_packet_shifter_pkg.sv
// Shared types and constants for the USB TX packet shifter.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC,
    EOP
  } tx_state_e;

  localparam logic [7:0]  SYNC_PATTERN = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam int unsigned STUFF_LIMIT  = 6;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_packet_shifter_if.sv
// Byte-level handshake between the TX protocol controller and the packet shifter.
interface usb_tx_packet_shifter_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_last;
  logic       tx_data_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_start, tx_pid, tx_has_data, tx_data, tx_data_valid, tx_data_last,
    input  tx_data_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_start, tx_pid, tx_has_data, tx_data, tx_data_valid, tx_data_last,
    output tx_data_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_packet_shifter_crc16.sv
// Serial CRC16 (poly 0x8005), one update per enabled bit.
module tx_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = bit_in ^ crc_q[15];
    crc_d = crc_q;
    if (clear)   crc_d = CRC16_INIT;
    else if (en) crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/usb_tx_packet_shifter.sv
// Serialises SYNC/PID/DATA/CRC16/EOP with bit stuffing for the NRZI encoder.
module usb_tx_packet_shifter
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  usb_tx_packet_shifter_if.slave  bus,
  output logic                    d_orig,
  output logic                    idle,
  output logic                    eop,
  output logic                    sync_shift_enable,
  output logic                    pid_shift_enable,
  output logic                    crc5_shift_enable,
  output logic                    crc16_shift_enable,
  output logic                    data_shift_enable,
  output logic                    bit_strobe
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  ones_q, ones_d;
  logic        d_orig_q, d_orig_d;
  logic [7:0]  pid_q, pid_d;
  logic        has_data_q, has_data_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        boundary, ready, crc_clear, crc_en, crc_bit;
  logic        shift, new_bit, take_byte, go_crc, go_eop;
  logic [15:0] crc;

  tx_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ones_d     = ones_q;
    d_orig_d   = d_orig_q;
    pid_d      = pid_q;
    has_data_d = has_data_q;
    byte_d     = byte_q;
    last_d     = last_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    cnt_d      = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
    boundary   = (cnt_q == CW'(CLKS_PER_BIT - 1));
    ready      = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    crc_bit    = 1'b0;
    shift      = 1'b0;
    new_bit    = 1'b0;
    take_byte  = 1'b0;
    go_crc     = 1'b0;
    go_eop     = 1'b0;

    if (state_q == IDLE) begin
      if (bus.tx_start) begin
        state_d    = SYNC;
        idx_d      = '0;
        cnt_d      = '0;
        ones_d     = '0;
        d_orig_d   = SYNC_PATTERN[0];
        pid_d      = pid_byte(bus.tx_pid);
        has_data_d = bus.tx_has_data;
        crc_clear  = 1'b1;
      end
    end else if (boundary) begin
      // Stuffed bit: field position, CRC and enables hold for one bit time.
      if (state_q != EOP && ones_q == 3'(STUFF_LIMIT)) begin
        d_orig_d = 1'b0;
        ones_d   = '0;
      end else begin
        case (state_q)
          SYNC: begin
            if (idx_q != 4'd7) begin
              idx_d   = idx_q + 4'd1;
              new_bit = SYNC_PATTERN[idx_d[2:0]];
              shift   = 1'b1;
            end else begin
              state_d = PID;
              idx_d   = '0;
              new_bit = pid_q[0];
              shift   = 1'b1;
            end
          end
          PID: begin
            if (idx_q != 4'd7) begin
              idx_d   = idx_q + 4'd1;
              new_bit = pid_q[idx_d[2:0]];
              shift   = 1'b1;
            end else if (!has_data_q)    go_eop    = 1'b1;
            else if (bus.tx_data_valid)  take_byte = 1'b1;
            else                         go_crc    = 1'b1;
          end
          DATA: begin
            if (idx_q != 4'd7) begin
              idx_d   = idx_q + 4'd1;
              new_bit = byte_q[idx_d[2:0]];
              shift   = 1'b1;
              crc_en  = 1'b1;
              crc_bit = new_bit;
            end else if (last_q)         go_crc    = 1'b1;
            else if (bus.tx_data_valid)  take_byte = 1'b1;
            else begin
              error_d = 1'b1;
              go_eop  = 1'b1;
            end
          end
          CRC: begin
            if (idx_q != 4'd15) begin
              idx_d   = idx_q + 4'd1;
              new_bit = ~crc[4'd15 - idx_d];
              shift   = 1'b1;
            end else go_eop = 1'b1;
          end
          EOP: begin
            if (idx_q == 4'd2) begin
              state_d  = IDLE;
              idx_d    = '0;
              d_orig_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              idx_d    = idx_q + 4'd1;
              d_orig_d = (idx_q == 4'd1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (take_byte) begin
      state_d = DATA;
      idx_d   = '0;
      ready   = 1'b1;
      byte_d  = bus.tx_data;
      last_d  = bus.tx_data_last;
      new_bit = bus.tx_data[0];
      shift   = 1'b1;
      crc_en  = 1'b1;
      crc_bit = new_bit;
    end
    if (go_crc) begin
      state_d = CRC;
      idx_d   = '0;
      new_bit = ~crc[15];
      shift   = 1'b1;
    end
    if (go_eop) begin
      state_d  = EOP;
      idx_d    = '0;
      d_orig_d = 1'b0;
      ones_d   = '0;
    end
    if (shift) begin
      d_orig_d = new_bit;
      ones_d   = new_bit ? ones_q + 3'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ones_q     <= '0;
      d_orig_q   <= 1'b1;
      pid_q      <= '0;
      has_data_q <= 1'b0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ones_q     <= ones_d;
      d_orig_q   <= d_orig_d;
      pid_q      <= pid_d;
      has_data_q <= has_data_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign d_orig             = d_orig_q;
  assign idle               = (state_q == IDLE) || (state_q == EOP && idx_q == 4'd2);
  assign eop                = (state_q == EOP) && (idx_q != 4'd2);
  assign sync_shift_enable  = (state_q == SYNC);
  assign pid_shift_enable   = (state_q == PID);
  assign crc5_shift_enable  = 1'b0;
  assign crc16_shift_enable = (state_q == CRC);
  assign data_shift_enable  = (state_q == DATA);
  assign bit_strobe         = (state_q != IDLE) && (cnt_q == '0);

  assign bus.tx_data_ready  = ready;
  assign bus.tx_busy        = (state_q != IDLE);
  assign bus.tx_done        = done_q;
  assign bus.tx_error       = error_q;
endmodule

// File: tb/tb_usb_tx_packet_shifter.sv
// Directed bench with a per-bit-time scoreboard for usb_tx_packet_shifter.
module tb_usb_tx_packet_shifter;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_packet_shifter_if bus();
  logic d_orig, idle, eop, sync_en, pid_en, crc5_en, crc16_en, data_en, bit_strobe;

  usb_tx_packet_shifter #(.CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .bus                (bus),
    .d_orig             (d_orig),
    .idle               (idle),
    .eop                (eop),
    .sync_shift_enable  (sync_en),
    .pid_shift_enable   (pid_en),
    .crc5_shift_enable  (crc5_en),
    .crc16_shift_enable (crc16_en),
    .data_shift_enable  (data_en),
    .bit_strobe         (bit_strobe)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  // {d_orig, sync, pid, data, crc16, eop, idle} per bit time
  logic [6:0] exp_q[$];
  logic [7:0] pkt_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected(input logic [3:0] pid, input logic has_data, input logic underrun);
    logic [4:0]  raw[$];
    logic [15:0] crc = 16'hFFFF;
    logic [7:0]  pb;
    logic [7:0]  by;
    logic        b, fb;
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) raw.push_back({(i == 7), 4'b1000});
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) raw.push_back({pb[i], 4'b0100});
    if (has_data) begin
      for (int k = 0; k < pkt_bytes.size(); k++) begin
        by = pkt_bytes[k];
        for (int i = 0; i < 8; i++) begin
          b  = by[i];
          raw.push_back({b, 4'b0010});
          fb  = b ^ crc[15];
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      if (!underrun)
        for (int i = 15; i >= 0; i--) raw.push_back({~crc[i], 4'b0001});
    end
    for (int k = 0; k < raw.size(); k++) begin
      exp_q.push_back({raw[k], 2'b00});
      ones = raw[k][4] ? ones + 1 : 0;
      if (ones == 6) begin
        exp_q.push_back({1'b0, raw[k][3:0], 2'b00});
        ones = 0;
      end
    end
    exp_q.push_back(7'b0_0000_10);
    exp_q.push_back(7'b0_0000_10);
    exp_q.push_back(7'b1_0000_01);
  endtask

  task automatic run_packet(input logic [3:0] pid, input logic has_data, input logic underrun,
                            input logic poke);
    int unsigned bidx = 0, cyc = 0, last_strobe = 0, ready_cnt = 0, err_cnt = 0;
    logic        done_seen = 1'b0, ready_now;
    logic [6:0]  got, held = '0, e;
    exp_q.delete();
    build_expected(pid, has_data, underrun);
    bus.tx_data_valid = has_data && (pkt_bytes.size() > 0);
    bus.tx_data       = (pkt_bytes.size() > 0) ? pkt_bytes[0] : 8'h00;
    bus.tx_data_last  = (pkt_bytes.size() == 1) && !underrun;
    bus.tx_pid        = pid;
    bus.tx_has_data   = has_data;
    bus.tx_start      = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      got = {d_orig, sync_en, pid_en, data_en, crc16_en, eop, idle};
      chk("busy", bus.tx_busy, !bus.tx_done);
      chk("crc5_en", crc5_en, 1'b0);
      if (bit_strobe) begin
        if (last_strobe == 0) chk("first_bit_latency", cyc, 1);
        else                  chk("bit_period", cyc - last_strobe, CPB);
        last_strobe = cyc;
        if (exp_q.size() == 0) chk("extra_bit_queue_len", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("bit", got, e);
        end
        held = got;
      end else chk("hold", got, held);
      if (bus.tx_error) begin
        err_cnt++;
        chk("error_at_eop", {bit_strobe, eop}, 2'b11);
      end
      ready_now = bus.tx_data_ready;
      if (ready_now) ready_cnt++;
      if (bus.tx_done) done_seen = 1'b1;
      if (poke && cyc == 10) begin
        bus.tx_start = 1'b1;
        bus.tx_pid   = 4'h5;
      end
      @(posedge clk); #1;
      bus.tx_start = 1'b0;
      if (ready_now) begin
        bidx++;
        if (bidx < pkt_bytes.size()) begin
          bus.tx_data      = pkt_bytes[bidx];
          bus.tx_data_last = (bidx == pkt_bytes.size() - 1) && !underrun;
        end else bus.tx_data_valid = 1'b0;
      end
    end
    chk("done_seen", done_seen, 1'b1);
    chk("bits_left", exp_q.size(), 0);
    chk("ready_pulses", ready_cnt, has_data ? pkt_bytes.size() : 0);
    chk("error_pulses", err_cnt, underrun);
    @(negedge clk);
    chk("done_one_cycle", bus.tx_done, 1'b0);
    chk("idle_after", {idle, d_orig, bit_strobe, bus.tx_busy}, 4'b1100);
    bus.tx_data_valid = 1'b0;
    bus.tx_data_last  = 1'b0;
  endtask

  initial begin
    int unsigned wait_cyc;
    n_rst             = 1'b0;
    bus.tx_start      = 1'b0;
    bus.tx_pid        = '0;
    bus.tx_has_data   = 1'b0;
    bus.tx_data       = '0;
    bus.tx_data_valid = 1'b0;
    bus.tx_data_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_values",
        {d_orig, idle, eop, sync_en, pid_en, crc5_en, crc16_en, data_en, bit_strobe,
         bus.tx_busy, bus.tx_done, bus.tx_error, bus.tx_data_ready}, 13'b1100000000000);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    pkt_bytes = {};
    run_packet(4'h2, 1'b0, 1'b0, 1'b0);       // ACK
    pkt_bytes = {};
    run_packet(4'h3, 1'b1, 1'b0, 1'b0);       // DATA0 zero-length
    pkt_bytes = {8'hFF, 8'hFF};
    run_packet(4'hB, 1'b1, 1'b0, 1'b0);       // DATA1 with stuffing
    pkt_bytes = {8'h01};
    run_packet(4'h3, 1'b1, 1'b1, 1'b0);       // underrun

    // Reset in the middle of DATA
    pkt_bytes = {};
    bus.tx_pid = 4'h3; bus.tx_has_data = 1'b1;
    bus.tx_data = 8'hA5; bus.tx_data_valid = 1'b1; bus.tx_data_last = 1'b0;
    bus.tx_start = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    wait_cyc = 0;
    while (!data_en && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("reached_data", data_en, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("reset_mid_packet",
        {idle, d_orig, eop, sync_en, pid_en, data_en, crc16_en, bit_strobe, bus.tx_busy},
        9'b110000000);
    bus.tx_data_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_held",
        {idle, d_orig, eop, sync_en, pid_en, data_en, crc16_en, bit_strobe, bus.tx_done},
        9'b110000000);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    pkt_bytes = {8'h3F, 8'hFC};
    run_packet(4'h3, 1'b1, 1'b0, 1'b0);       // clean packet after reset

    pkt_bytes = {};
    run_packet(4'hA, 1'b0, 1'b0, 1'b1);       // tx_start while busy is ignored

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed simulation still running, expected finished");
    $fatal(1);
  end
endmodule
